// File: rtl/instruction_fetch.sv
// RV64 fetch stage: PC, req/ack instruction-memory port, instruction register and decode handshake.
// Optional IFETCH_MISALIGN_TRAP_EN adds a misaligned-redirect trap state and the misalign_trap output.
module instruction_fetch #(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     instruction,
   output logic [XLEN-1:0] inst_pc,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc
`ifdef IFETCH_MISALIGN_TRAP_EN
   ,
   output logic            misalign_trap
`endif
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_HOLD,
      S_DRAIN
`ifdef IFETCH_MISALIGN_TRAP_EN
      ,
      S_TRAP
`endif
   } state_t;

   state_t          state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] next_addr;
   logic            issue;
`ifdef IFETCH_MISALIGN_TRAP_EN
   logic            misaligned;
`endif

   // issue: a new request (or a trap) is launched from pc or from the redirect target this cycle
   always_comb begin
`ifdef IFETCH_MISALIGN_TRAP_EN
      target = redirect_pc;
`else
      target = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
`endif
      next_addr = redirect ? target : pc;
      issue = (state == S_IDLE)
            || (state == S_REQ && !imem_req)
            || (state == S_HOLD && (redirect || inst_ready))
`ifdef IFETCH_MISALIGN_TRAP_EN
            || (state == S_TRAP && redirect)
`endif
            ;
`ifdef IFETCH_MISALIGN_TRAP_EN
      misaligned = |next_addr[1:0];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         imem_req    <= 1'b0;
         imem_addr   <= RESET_PC;
         inst_valid  <= 1'b0;
         inst_pc     <= '0;
         instruction <= NOP;
`ifdef IFETCH_MISALIGN_TRAP_EN
         misalign_trap <= 1'b0;
`endif
      end else if (issue) begin
         pc         <= next_addr;
         inst_valid <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
         misalign_trap <= misaligned;
         if (misaligned) begin
            state    <= S_TRAP;
            imem_req <= 1'b0;
         end else begin
            state     <= S_REQ;
            imem_req  <= 1'b1;
            imem_addr <= next_addr;
         end
`else
         state     <= S_REQ;
         imem_req  <= 1'b1;
         imem_addr <= next_addr;
`endif
      end else begin
         case (state)
            S_REQ: begin
               // an outstanding request is never withdrawn; a redirect without ack must drain it
               if (redirect) begin
                  pc <= target;
                  if (imem_ack) begin
                     imem_req <= 1'b0;
                  end else begin
                     state <= S_DRAIN;
                  end
               end else if (imem_ack) begin
                  instruction <= imem_rdata;
                  inst_pc     <= pc;
                  pc          <= pc + XLEN'(4);
                  imem_req    <= 1'b0;
                  inst_valid  <= 1'b1;
                  state       <= S_HOLD;
               end
            end
            S_DRAIN: begin
               if (redirect) begin
                  pc <= target;
               end
               if (imem_ack) begin
                  imem_req <= 1'b0;
                  state    <= S_REQ;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
